pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines four inputs into per-stage pipeline-register load and flush enables:
  - the load-use bubble from the forwarding unit;
  - I-cache and D-cache handshakes;
  - EX-stage control-flow redirects.
- Holds a redirect that arrives while an instruction fetch is outstanding, then applies it once the fetch returns.
- Keeps performance counters for stall and flush cycles.

Parameters:
CNT_WIDTH, 32, width of stall_cycles and flush_events counters (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk)
load_use_bubble  in  1  forwarding unit: EX instr needs a result still being loaded in MEM
imem_read  in  1  fetch request outstanding this cycle
imem_resp  in  1  I-cache response, one-cycle pulse
dmem_req  in  1  MEM-stage load/store active
dmem_resp  in  1  D-cache response, one-cycle pulse
redirect  in  1  EX resolved taken branch/jal/jalr
redirect_target  in  32  target PC for redirect
load_pc  out  1  PC register enable
load_if_id  out  1  IF/ID enable
load_id_ex  out  1  ID/EX enable
load_ex_mem  out  1  EX/MEM enable
load_mem_wb  out  1  MEM/WB enable
flush_if_id  out  1  IF/ID loads NOP on this edge
flush_id_ex  out  1  ID/EX loads NOP
flush_ex_mem  out  1  EX/MEM loads NOP
pc_override  out  1  PC mux selects pc_override_val instead of normal next-PC
pc_override_val  out  32  PC to load when pc_override
stall_cycles  out  CNT_WIDTH  cycles with load_pc==0
flush_events  out  CNT_WIDTH  count of applied redirects

Behaviour:
- States: RUN, DRAIN. Reset → RUN; held target register = 0; both counters = 0.
- Output values while rst==0 (held for the reset cycle): all load_* = 1, all flush_* = 0, pc_override = 0, pc_override_val = 0.
- Derived signals:
  - istall = imem_read & ~imem_resp
  - dstall = dmem_req & ~dmem_resp
- Outputs are combinational from state and inputs; state, target register and counters update at posedge clk.
- RUN, priority order (first match wins):
  1. dstall: every load_* = 0 and every flush_* = 0. The whole pipeline freezes, and redirect is ignored this cycle (EX is frozen, so it will reassert).
  2. load_use_bubble:
     - load_pc = load_if_id = load_id_ex = 0;
     - load_ex_mem = load_mem_wb = 1;
     - flush_ex_mem = 1, inserting a bubble into MEM.
     - redirect is ignored (the EX instr has not executed).
  3. redirect & ~istall: all load_* = 1, flush_if_id = 1, flush_id_ex = 1, pc_override = 1, pc_override_val = redirect_target; flush_events increments.
  4. redirect & istall:
     - latch redirect_target into the held register; go to DRAIN;
     - load_pc = load_if_id = 0;
     - load_id_ex = 1 with flush_id_ex = 1;
     - load_ex_mem = load_mem_wb = 1, so the branch advances.
  5. istall: load_pc = load_if_id = load_id_ex = 0; flush_id_ex = 0; load_ex_mem = load_mem_wb = 1 with flush_ex_mem = 1, so downstream drains.
  6. Otherwise all load_* = 1, no flushes.
- DRAIN (waiting for the stale fetch):
  - When imem_resp == 0: load_pc = load_if_id = 0; load_id_ex = 1 with flush_id_ex = 1; load_ex_mem = load_mem_wb = 1. dstall overrides this with a full freeze.
  - When imem_resp == 1: discard the returned instruction (load_if_id = 1, flush_if_id = 1); load_pc = 1 with pc_override = 1 and pc_override_val = held target; flush_events increments; go to RUN. Under dstall the exit is deferred one cycle, but the arrived response is not lost: it is recorded as a "resp_seen" flag.
  - A new redirect in DRAIN cannot occur, because ID/EX is flushed; if it is asserted anyway, it is ignored.
- stall_cycles increments every cycle load_pc == 0 and rst == 1; both counters saturate at all-ones.
- Reset mid-DRAIN: returns to RUN and discards the held target. The outstanding fetch response that follows is not flushed; the cache is reset by the same rst.

Test Plan:
- Idle: imem_read=1, imem_resp=1 every cycle, no hazards → all load_*=1, no flushes, stall_cycles stays 0 over 20 cycles.
- Load-use: assert load_use_bubble for 1 cycle → that cycle load_pc/if_id/id_ex=0, flush_ex_mem=1; next cycle all loads=1; stall_cycles=1.
- Redirect without fetch stall: redirect=1, redirect_target=0x60000040 → same cycle flush_if_id=flush_id_ex=1, pc_override=1, pc_override_val=0x60000040; flush_events=1.
- Redirect during fetch miss: imem_read=1, imem_resp=0, redirect with target 0x600000A0, resp after 4 cycles:
  - state DRAIN for 4 cycles with load_pc=0;
  - on the resp cycle flush_if_id=1, pc_override_val=0x600000A0;
  - stall_cycles=4.
- D-cache stall dominance: dmem_req=1, resp after 3 cycles, with load_use_bubble and redirect also asserted → 3 cycles all load_*=0, no flushes, flush_events unchanged; rst=0 mid-DRAIN → next cycle RUN, counters 0, pc_override=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_bubble,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 pc_override,
  output logic [31:0]          pc_override_val,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] held, held_n;
  logic resp_seen, resp_seen_n, inc_flush;
  logic istall, dstall;
  assign istall = imem_read & ~imem_resp;
  assign dstall = dmem_req & ~dmem_resp;
  // next-state and per-stage enables; reset forces the all-load, no-flush pattern
  always_comb begin
    {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '1;
    {flush_if_id, flush_id_ex, flush_ex_mem, pc_override} = '0;
    pc_override_val = '0;
    state_n = state;
    held_n = held;
    resp_seen_n = resp_seen;
    inc_flush = 1'b0;
    if (rst) begin
      if (dstall) begin
        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '0;
        if (state == DRAIN) resp_seen_n = resp_seen | imem_resp;
      end else if (state == DRAIN) begin
        if (imem_resp | resp_seen) begin
          flush_if_id = 1'b1;
          pc_override = 1'b1;
          pc_override_val = held;
          inc_flush = 1'b1;
          state_n = RUN;
          resp_seen_n = 1'b0;
        end else begin
          {load_pc, load_if_id} = '0;
          flush_id_ex = 1'b1;
        end
      end else if (load_use_bubble) begin
        {load_pc, load_if_id, load_id_ex} = '0;
        flush_ex_mem = 1'b1;
      end else if (redirect && !istall) begin
        {flush_if_id, flush_id_ex, pc_override} = '1;
        pc_override_val = redirect_target;
        inc_flush = 1'b1;
      end else if (redirect) begin
        {load_pc, load_if_id} = '0;
        flush_id_ex = 1'b1;
        held_n = redirect_target;
        state_n = DRAIN;
      end else if (istall) begin
        {load_pc, load_if_id, load_id_ex} = '0;
        flush_ex_mem = 1'b1;
      end
    end
  end
  // state, held target and saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      held <= '0;
      resp_seen <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_n;
      held <= held_n;
      resp_seen <= resp_seen_n;
      if (!load_pc && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (inc_flush && !(&flush_events)) flush_events <= flush_events + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic load_use_bubble = 0, imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0, redirect = 0;
  logic [31:0] redirect_target = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, pc_override;
  logic [31:0] pc_override_val, stall_cycles, flush_events;
  int tests = 0, fails = 0;
  logic m_drain = 0, m_seen = 0;
  logic [31:0] m_held = 0, m_stall = 0, m_flush = 0;

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_use_bubble(load_use_bubble), .imem_read(imem_read),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp), .redirect(redirect),
    .redirect_target(redirect_target), .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_override(pc_override), .pc_override_val(pc_override_val),
    .stall_cycles(stall_cycles), .flush_events(flush_events));

  always #5 clk = ~clk;

  // one cycle: drive at negedge, check outputs, then advance the model to the next edge
  task automatic step(input logic r, lub, ir, irs, dr, drs, rd, input logic [31:0] tgt);
    logic [8:0] e, got;
    logic [31:0] ev;
    logic is, ds, inc;
    @(negedge clk);
    {rst, load_use_bubble, imem_read, imem_resp, dmem_req, dmem_resp, redirect} = {r, lub, ir, irs, dr, drs, rd};
    redirect_target = tgt;
    #1;
    is = ir & ~irs;
    ds = dr & ~drs;
    e = 9'b11111_000_0;
    ev = 0;
    inc = 0;
    if (!r) begin
    end else if (ds) begin
      e = 0;
      if (m_drain) m_seen = m_seen | irs;
    end else if (m_drain) begin
      if (irs | m_seen) begin
        e = 9'b11111_100_1; ev = m_held; inc = 1; m_drain = 0; m_seen = 0;
      end else e = 9'b00111_010_0;
    end else if (lub) e = 9'b00011_001_0;
    else if (rd & ~is) begin
      e = 9'b11111_110_1; ev = tgt; inc = 1;
    end else if (rd) begin
      e = 9'b00111_010_0; m_held = tgt; m_drain = 1;
    end else if (is) e = 9'b00011_001_0;
    got = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, pc_override};
    tests += 4;
    assert (got === e) else begin fails++; $error("FAIL enables got=%b exp=%b", got, e); end
    assert (pc_override_val === ev) else begin fails++; $error("FAIL pc_val got=%h exp=%h", pc_override_val, ev); end
    assert (stall_cycles === m_stall) else begin fails++; $error("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, m_stall); end
    assert (flush_events === m_flush) else begin fails++; $error("FAIL flush_events got=%0d exp=%0d", flush_events, m_flush); end
    if (!r) begin
      m_drain = 0; m_seen = 0; m_held = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[8] && m_stall != '1) m_stall++;
      if (inc && m_flush != '1) m_flush++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, exp);
    tests++;
    assert (got === exp) else begin fails++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask

  initial begin
    step(0, 1, 1, 0, 1, 0, 1, 32'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("idle_stall", stall_cycles, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("loaduse_stall", stall_cycles, 1);
    step(1, 0, 1, 1, 0, 0, 1, 32'h60000040);
    chk("redir_val", pc_override_val, 32'h60000040);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("redir_flush", flush_events, 1);
    step(1, 0, 1, 0, 0, 0, 1, 32'h600000A0);
    repeat (3) step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("drain_val", pc_override_val, 32'h600000A0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("drain_stall", stall_cycles, 5);
    chk("drain_flush", flush_events, 2);
    repeat (3) step(1, 1, 1, 1, 1, 0, 1, 32'h11);
    chk("dstall_flush", flush_events, 2);
    step(1, 0, 1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1, 32'h700);
    step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("resp_seen_val", pc_override_val, 32'h700);
    step(1, 0, 1, 0, 0, 0, 1, 32'h800);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    chk("rst_override", {31'b0, pc_override}, 0);
    chk("rst_stall", stall_cycles, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(49) != 0, $urandom_range(9) == 0, $urandom_range(3) != 0,
           $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0,
           $urandom_range(5) == 0, $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
